// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer for the EX stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; the divider stays iterative.
module muldiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam logic [4:0] OP_MUL    = 5'b10010;
  localparam logic [4:0] OP_MULH   = 5'b10011;
  localparam logic [4:0] OP_MULHSU = 5'b10100;
  localparam logic [4:0] OP_MULHU  = 5'b10101;
  localparam logic [4:0] OP_DIV    = 5'b10110;
  localparam logic [4:0] OP_DIVU   = 5'b10111;
  localparam logic [4:0] OP_REM    = 5'b11000;
  localparam logic [4:0] OP_REMU   = 5'b11001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_n;

  logic        is_md, is_mul_op, is_rem_op, a_signed, b_signed;
  logic        neg_a, neg_b, div_special, accept, last_iter;
  logic [31:0] abs_a, abs_b, special_res;

  logic [4:0]  op_q;
  logic        neg_a_q, neg_b_q;
  logic [5:0]  cnt;
  logic [31:0] mag_b, rem_q, quo_q;

  logic [32:0] div_shift, div_diff;
  logic [31:0] rem_n, quo_n, quo_fix, rem_fix, div_res;
  logic [31:0] mul_res;

  always_comb begin
    is_md       = in_valid && (op >= OP_MUL) && (op <= OP_REMU);
    is_mul_op   = (op <= OP_MULHU);
    is_rem_op   = (op == OP_REM) || (op == OP_REMU);
    a_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MUL) || (op == OP_MULH) ||
                  (op == OP_DIV) || (op == OP_REM);
    neg_a       = a_signed && a[31];
    neg_b       = b_signed && b[31];
    abs_a       = neg_a ? -a : a;
    abs_b       = neg_b ? -b : b;
    // Divide by zero and signed overflow finish without iterating.
    div_special = (b == 32'd0) ||
                  (((op == OP_DIV) || (op == OP_REM)) &&
                   (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    if (b == 32'd0) special_res = is_rem_op ? a : 32'hFFFF_FFFF;
    else            special_res = is_rem_op ? 32'd0 : 32'h8000_0000;
  end

  assign accept    = (state == IDLE) && is_md && !flush;
  assign last_iter = (cnt == 6'd31);

  // One restoring-divide step: remainder in rem_q, dividend bits shift out of quo_q.
  always_comb begin
    div_shift = {rem_q, quo_q[31]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (!div_diff[32]) begin
      rem_n = div_diff[31:0];
      quo_n = {quo_q[30:0], 1'b1};
    end else begin
      rem_n = div_shift[31:0];
      quo_n = {quo_q[30:0], 1'b0};
    end
    quo_fix = (neg_a_q ^ neg_b_q) ? -quo_n : quo_n;
    rem_fix = neg_a_q ? -rem_n : rem_n;
    div_res = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;

  // 64-bit extension gives the same low 64 bits as a 33x33 signed product.
  always_comb begin
    fast_a    = {{32{neg_a}}, a};
    fast_b    = {{32{neg_b}}, b};
    fast_prod = fast_a * fast_b;
    mul_res   = (op == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`else
  logic [31:0] mag_a;
  logic [63:0] acc, acc_n, prod_fix;
  logic [32:0] acc_sum;

  // Shift-add step: multiplier sits in acc[31:0] and is consumed LSB first.
  always_comb begin
    acc_sum  = {1'b0, acc[63:32]} + {1'b0, mag_a};
    acc_n    = acc[0] ? {acc_sum, acc[31:1]} : {1'b0, acc[63:1]};
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_n : acc_n;
    mul_res  = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            if (is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
              state_n = DONE;
`else
              state_n = MUL;
`endif
            end else begin
              state_n = div_special ? DONE : DIV;
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MUL:     if (last_iter) state_n = DONE;
`endif
        DIV:     if (last_iter) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    stall     = is_md && !out_valid;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q    <= 5'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      cnt     <= 6'd0;
      mag_b   <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      result  <= 32'd0;
`ifndef MULDIV_FAST_MUL_EN
      mag_a   <= 32'd0;
      acc     <= 64'd0;
`endif
    end else if (flush) begin
      cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mag_b   <= abs_b;
            cnt     <= 6'd0;
            rem_q   <= 32'd0;
            quo_q   <= abs_a;
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul_op) result <= mul_res;
`else
            mag_a   <= abs_a;
            acc     <= {32'd0, abs_b};
`endif
            if (!is_mul_op && div_special) result <= special_res;
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MUL: begin
          acc <= acc_n;
          cnt <= last_iter ? 6'd0 : cnt + 6'd1;
          if (last_iter) result <= mul_res;
        end
`endif
        DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt   <= last_iter ? 6'd0 : cnt + 6'd1;
          if (last_iter) result <= div_res;
        end
        default: cnt <= 6'd0;
      endcase
    end
  end

endmodule
